// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-stage register carrying an opaque payload and control bundle between
// adjacent processor stages over a valid/ready handshake. A synchronous flush inserts a bubble,
// and a saturating counter records back-pressure cycles.
//
// Build option: define PIPE_SKID_EN to add a skid register. in_ready_o then comes from a flop,
// so there is no combinational out_ready_i -> in_ready_o path. Without it the stage holds a
// single entry and in_ready_o follows out_ready_i combinationally.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   flush_i      synchronous flush; drops held entries and the input offered that cycle
//   in_valid_i   upstream entry present
//   in_ready_o   stage can accept an entry
//   in_data_i    upstream payload (DATA_W)
//   in_ctrl_i    upstream control (CTRL_W)
//   out_valid_o  entry held for downstream
//   out_ready_i  downstream accepts
//   out_data_o   held payload; keeps its last value when the stage is empty
//   out_ctrl_o   held control; reads 0 whenever out_valid_o = 0
//   stall_cnt_o  saturating count of cycles with out_valid_o = 1 and out_ready_i = 0
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Main register: drives the outputs.
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic xfer_in;
  logic m_load;

  assign xfer_in = in_valid_i && in_ready_o && !flush_i;
  assign m_load  = !m_valid_q || out_ready_i;

`ifdef PIPE_SKID_EN
  // Skid register: catches the entry accepted while M is stalled.
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  // Only the flush term is combinational; out_ready_i never reaches in_ready_o.
  assign in_ready_o = !s_valid_q && !flush_i;

  always_comb begin
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush_i) begin
      s_valid_d = 1'b0;
    end else if (m_load && s_valid_q) begin
      s_valid_d = 1'b0;
    end else if (xfer_in && m_valid_q && !out_ready_i) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
      s_ctrl_d  = in_ctrl_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end
`else
  assign in_ready_o = !flush_i && (out_ready_i || !m_valid_q);
`endif

  // Payload registers are not cleared on flush or drain; only valid drops.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
    end else if (m_load) begin
`ifdef PIPE_SKID_EN
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
      end else
`endif
      if (xfer_in) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data_i;
        m_ctrl_d  = in_ctrl_i;
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;
  // A bubble must never present live enables downstream.
  assign out_ctrl_o  = m_valid_q ? m_ctrl_q : '0;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int unsigned DataW = 16;
  localparam int unsigned CtrlW = 4;
  localparam int unsigned CntW  = 4;

  logic             clk;
  logic             reset;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DataW-1:0] in_data_i;
  logic [CtrlW-1:0] in_ctrl_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DataW-1:0] out_data_o;
  logic [CtrlW-1:0] out_ctrl_o;
  logic [CntW-1:0]  stall_cnt_o;

  int checks;
  int errors;

  pipe_stage_buf #(
    .DATA_W(DataW),
    .CTRL_W(CtrlW),
    .CNT_W (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_ctrl_i  (in_ctrl_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_ctrl_o (out_ctrl_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_ctrl_i   = '0;
    out_ready_i = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl_o), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    reset = 1'b0;

    // Stream 1..8 at full rate
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_i = DataW'(i);
      in_ctrl_i = CtrlW'(i);
      tick();
      chk("stream_valid", 64'(out_valid_o), 64'd1);
      chk("stream_data", 64'(out_data_o), 64'(i));
      chk("stream_ctrl", 64'(out_ctrl_o), 64'(i & 15));
      chk("stream_in_ready", 64'(in_ready_o), 64'd1);
    end
    in_valid_i = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid_o), 64'd0);
    chk("drain_ctrl", 64'(out_ctrl_o), 64'd0);
    chk("drain_data_hold", 64'(out_data_o), 64'h8);
    chk("stream_stall", 64'(stall_cnt_o), 64'd0);

    // Back-pressure
    in_valid_i = 1'b1;
    in_data_i  = 16'h000A;
    in_ctrl_i  = 4'h3;
    tick();
    chk("bp_load_a", 64'(out_data_o), 64'hA);
    out_ready_i = 1'b0;
    in_data_i   = 16'h000B;
    in_ctrl_i   = 4'h4;
    #1;
`ifdef PIPE_SKID_EN
    chk("bp_in_ready_s_empty", 64'(in_ready_o), 64'd1);
`else
    chk("bp_in_ready_follows_0", 64'(in_ready_o), 64'd0);
`endif
    tick();
    chk("bp_hold_a", 64'(out_data_o), 64'hA);
    chk("bp_hold_ctrl", 64'(out_ctrl_o), 64'h3);
    chk("bp_stall1", 64'(stall_cnt_o), 64'd1);
    chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
    in_data_i = 16'h000C;
    in_ctrl_i = 4'h5;
    tick();
    chk("bp_hold_a2", 64'(out_data_o), 64'hA);
    chk("bp_stall2", 64'(stall_cnt_o), 64'd2);
    out_ready_i = 1'b1;
    #1;
`ifdef PIPE_SKID_EN
    chk("bp_in_ready_s_full", 64'(in_ready_o), 64'd0);
    tick();
    chk("bp_out_b", 64'(out_data_o), 64'hB);
    chk("bp_out_b_ctrl", 64'(out_ctrl_o), 64'h4);
    chk("bp_in_ready_back", 64'(in_ready_o), 64'd1);
    tick();
    chk("bp_out_c", 64'(out_data_o), 64'hC);
`else
    chk("bp_in_ready_follows_1", 64'(in_ready_o), 64'd1);
    tick();
    chk("bp_out_c", 64'(out_data_o), 64'hC);
    chk("bp_out_c_ctrl", 64'(out_ctrl_o), 64'h5);
`endif
    chk("bp_stall_kept", 64'(stall_cnt_o), 64'd2);
    in_valid_i = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid_o), 64'd0);

    // Flush drops held entry and the offered input
    in_valid_i = 1'b1;
    in_data_i  = 16'h0055;
    in_ctrl_i  = 4'b0101;
    tick();
    chk("fl_pre_ctrl", 64'(out_ctrl_o), 64'h5);
    flush_i   = 1'b1;
    in_data_i = 16'h0066;
    in_ctrl_i = 4'hF;
    #1;
    chk("fl_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl_o), 64'd0);
    chk("fl_data_hold", 64'(out_data_o), 64'h55);
    tick();
    chk("fl_input_dropped", 64'(out_valid_o), 64'd0);

    // Saturation of the 4-bit stall counter
    in_valid_i = 1'b1;
    in_data_i  = 16'h0077;
    in_ctrl_i  = 4'h2;
    tick();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 12) chk("sat_14", 64'(stall_cnt_o), 64'd14);
      if (k == 13) chk("sat_15", 64'(stall_cnt_o), 64'd15);
    end
    chk("sat_hold", 64'(stall_cnt_o), 64'd15);
    chk("sat_data", 64'(out_data_o), 64'h77);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("sat_flush_valid", 64'(out_valid_o), 64'd0);
    chk("sat_not_cleared", 64'(stall_cnt_o), 64'd15);

    // Asynchronous reset mid-stall
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0099;
    in_ctrl_i   = 4'h6;
    tick();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk("ar_pre_valid", 64'(out_valid_o), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid_o), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl_o), 64'd0);
    chk("ar_data", 64'(out_data_o), 64'd0);
    chk("ar_stall", 64'(stall_cnt_o), 64'd0);
    chk("ar_in_ready", 64'(in_ready_o), 64'd1);
    #1;
    reset = 1'b0;

    // First edge after release accepts
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0011;
    in_ctrl_i   = 4'h1;
    tick();
    chk("post_rst_valid", 64'(out_valid_o), 64'd1);
    chk("post_rst_data", 64'(out_data_o), 64'h11);
    in_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
